// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, CTRL bit indices and enums shared by the PWM bank.
package pwm_pkg;
  localparam logic [5:0] ADDR_CTRL   = 6'd0;
  localparam logic [5:0] ADDR_PRESC  = 6'd1;
  localparam logic [5:0] ADDR_PERIOD = 6'd2;
  localparam logic [5:0] ADDR_CMP0   = 6'd3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} cnt_state_e;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;
endpackage

// File: rtl/pwm_cmp_ch.sv
// pwm_cmp_ch: one channel's shadow/active compare registers and its output flop.
module pwm_cmp_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_data,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] o_shadow,
  output logic             o_pwm
);
  logic [CNT_W-1:0] r_sh, r_act;
  logic             r_pwm;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sh  <= '0;
      r_act <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (i_wr) r_sh <= i_data;
      if (i_load) r_act <= r_sh;
      r_pwm <= i_run && (i_cnt < r_act);
    end
  end
  assign o_shadow = r_sh;
  assign o_pwm    = r_pwm;
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CH_NUM PWM channels sharing one prescaled counter with shadowed PERIOD/CMP.
// Define PWM_CENTER_ALIGN_EN to build the center-aligned mode (MODE bit, DOWN state).
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [5:0]        rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [CH_NUM-1:0] pwm_out,
  output logic              update_tick
);
  logic               r_en, r_upd;
  logic [PRESC_W-1:0] r_presc, r_pcnt;
  logic [CNT_W-1:0]   r_period_sh, r_period, r_cnt, r_rd, w_nxt, w_rd;
  logic [CNT_W-1:0]   w_cmp_sh [CH_NUM];
  cnt_state_e         r_state, w_nxt_st;
  mode_e              w_mode;
  logic               w_ce, w_upd, w_load, w_run;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en        <= 1'b0;
      r_presc     <= '0;
      r_period_sh <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_CTRL) r_en <= wr_data[CTRL_EN];
      if (wr_addr == ADDR_PRESC) r_presc <= wr_data[PRESC_W-1:0];
      if (wr_addr == ADDR_PERIOD) r_period_sh <= wr_data;
    end
  end
`ifdef PWM_CENTER_ALIGN_EN
  mode_e r_mode;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_mode <= MODE_EDGE;
    else if (wr_en && wr_addr == ADDR_CTRL) r_mode <= mode_e'(wr_data[CTRL_MODE]);
  end
  assign w_mode = r_mode;
`else
  assign w_mode = MODE_EDGE;
`endif
  // Both modes signal the update event by the counter returning to 0 on a count-enable.
  always_comb begin
    w_nxt    = (r_cnt >= r_period) ? '0 : r_cnt + 1'b1;
    w_nxt_st = ST_UP;
`ifdef PWM_CENTER_ALIGN_EN
    if (w_mode == MODE_CENTER && r_period != '0) begin
      w_nxt    = (r_state == ST_UP && r_cnt < r_period) ? r_cnt + 1'b1 : r_cnt - 1'b1;
      w_nxt_st = (w_nxt == '0 || (r_state == ST_UP && r_cnt < r_period)) ? ST_UP : ST_DOWN;
    end
`endif
  end
  assign w_ce   = (r_state != ST_IDLE) && (r_pcnt >= r_presc);
  assign w_upd  = w_ce && (w_nxt == '0);
  assign w_load = (r_state == ST_IDLE) || w_upd;
  assign w_run  = r_en && (r_state != ST_IDLE);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_upd   <= 1'b0;
    end else if (!r_en) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= w_upd;
      if (r_state == ST_IDLE) r_state <= ST_UP;
      else begin
        r_pcnt <= w_ce ? '0 : r_pcnt + 1'b1;
        if (w_ce) begin
          r_cnt   <= w_nxt;
          r_state <= w_nxt_st;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_period <= '0;
    else if (w_load) r_period <= r_period_sh;
  end
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_cmp_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .i_wr    (wr_en && wr_addr == ADDR_CMP0 + 6'(i)),
      .i_data  (wr_data),
      .i_load  (w_load),
      .i_run   (w_run),
      .i_cnt   (r_cnt),
      .o_shadow(w_cmp_sh[i]),
      .o_pwm   (pwm_out[i])
    );
  end
  always_comb begin
    w_rd = (rd_addr == ADDR_CTRL)   ? CNT_W'({w_mode == MODE_CENTER, r_en}) :
           (rd_addr == ADDR_PRESC)  ? CNT_W'(r_presc) :
           (rd_addr == ADDR_PERIOD) ? r_period_sh : '0;
    for (int i = 0; i < CH_NUM; i++)
      if (rd_addr == ADDR_CMP0 + 6'(i)) w_rd = w_cmp_sh[i];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rd <= '0;
    else r_rd <= w_rd;
  end
  assign rd_data     = r_rd;
  assign update_tick = r_upd;
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: random + directed stimulus, tick-level reference model, scoreboard monitor.
module tb_pwm_bank;
  localparam int CH = 8;
  logic        clk = 1'b0, resetn, wr_en, rd_rand;
  logic [5:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic [CH-1:0] pwm_out;
  logic        update_tick;

  pwm_bank #(.CH_NUM(CH), .CNT_W(16), .PRESC_W(8)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .update_tick(update_tick)
  );

  always #5 clk = ~clk;
  always @(negedge clk) rd_addr = rd_rand ? 6'($urandom_range(0, 40)) : 6'd2;

  typedef struct { logic [CH-1:0] pwm; logic upd; logic [15:0] rd; } exp_t;
  exp_t q[$];
  string dn[$];
  int da[$], de[$];
  int n_vec = 0, n_err = 0;

  // Reference model: position within the PWM period (phase), not counter/direction flops.
  int m_en, m_mode, m_presc, m_psh, m_per, m_run, m_ph, m_pre;
  int m_csh[CH], m_cmp[CH];

  function automatic int rd_model(int a);
    if (a == 0) return m_en | (m_mode << 1);
    if (a == 1) return m_presc;
    if (a == 2) return m_psh;
    if (a >= 3 && a < 3 + CH) return m_csh[a-3];
    return 0;
  endfunction

  task automatic m_clear();
    m_en = 0; m_mode = 0; m_presc = 0; m_psh = 0; m_per = 0; m_run = 0; m_ph = 0; m_pre = 0;
    for (int i = 0; i < CH; i++) begin m_csh[i] = 0; m_cmp[i] = 0; end
  endtask

  task automatic m_step();
    exp_t e;
    int cnt, len, upd;
    cnt = (m_mode != 0 && m_ph > m_per) ? 2 * m_per - m_ph : m_ph;
    e.rd = 16'(rd_model(int'(rd_addr)));
    for (int i = 0; i < CH; i++) e.pwm[i] = (m_en != 0 && m_run != 0 && cnt < m_cmp[i]);
    upd = 0;
    if (m_run != 0) begin
      if (m_pre >= m_presc) begin
        m_pre = 0;
        len = (m_per == 0) ? 1 : (m_mode != 0) ? 2 * m_per : m_per + 1;
        m_ph = (m_ph + 1) % len;
        upd = (m_ph == 0);
      end else m_pre++;
    end
    if (m_run == 0 || upd != 0) begin
      m_per = m_psh;
      for (int i = 0; i < CH; i++) m_cmp[i] = m_csh[i];
    end
    e.upd = (upd != 0 && m_en != 0);
    if (m_en == 0) begin m_run = 0; m_ph = 0; m_pre = 0; end else m_run = 1;
    if (wr_en) begin
      if (wr_addr == 0) begin
        m_en = int'(wr_data[0]);
`ifdef PWM_CENTER_ALIGN_EN
        m_mode = int'(wr_data[1]);
`endif
      end
      if (wr_addr == 1) m_presc = int'(wr_data[7:0]);
      if (wr_addr == 2) m_psh = int'(wr_data);
      if (wr_addr >= 3 && wr_addr < 3 + CH) m_csh[wr_addr-3] = int'(wr_data);
    end
    q.push_back(e);
  endtask

  always @(posedge clk or negedge resetn)
    if (!resetn) m_clear();
    else m_step();

  // Monitor: pops one expected output set per cycle and evaluates queued direct checks.
  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      n_vec += 3;
      if (pwm_out !== me.pwm) begin n_err++; $display("FAIL pwm_out: got %b want %b @%0t", pwm_out, me.pwm, $time); end
      if (update_tick !== me.upd) begin n_err++; $display("FAIL update_tick: got %b want %b @%0t", update_tick, me.upd, $time); end
      if (rd_data !== me.rd) begin n_err++; $display("FAIL rd_data: got %0h want %0h @%0t", rd_data, me.rd, $time); end
    end
    while (dn.size() > 0) begin
      string n;
      int a, x;
      n = dn.pop_front(); a = da.pop_front(); x = de.pop_front();
      n_vec++;
      if (a != x) begin n_err++; $display("FAIL %s: got %0d want %0d", n, a, x); end
    end
  end

  task automatic chk(input string n, input int a, input int x);
    dn.push_back(n); da.push_back(a); de.push_back(x);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!update_tick && n < 400) begin @(negedge clk); n++; end
    if (!update_tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic tick_gap(input string nm, input int want);
    int n = 0;
    wait_tick();
    do begin @(negedge clk); n++; end while (!update_tick && n < 400);
    chk(nm, n, want);
  endtask

  initial begin
    int h0, h1, lo1, hi2, any;
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_rand = 1'b1;
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(update_tick), 0);
    chk("rst_rd", int'(rd_data), 0);
    @(negedge clk);
    resetn = 1'b1;
    // Edge-aligned duty and boundaries
    wr(6'd1, 16'd0); wr(6'd2, 16'd9); wr(6'd3, 16'd3); wr(6'd4, 16'd0); wr(6'd5, 16'd15);
    for (int i = 3; i < CH; i++) wr(6'(3 + i), 16'($urandom_range(0, 12)));
    wr(6'd0, 16'd1);
    tick_gap("edge_gap", 10);
    // Shadow write in the tick cycle: this period keeps 3, the next one uses 7
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'd7;
    h0 = 0; h1 = 0; lo1 = 0; hi2 = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) wr_en = 1'b0;
      if (i < 10) h0 += int'(pwm_out[0]); else h1 += int'(pwm_out[0]);
      lo1 |= int'(pwm_out[1]);
      hi2 &= int'(pwm_out[2]);
    end
    chk("duty_old_cmp", h0, 3);
    chk("duty_new_cmp", h1, 7);
    chk("cmp_zero_low", lo1, 0);
    chk("cmp_over_period_high", hi2, 1);
    // PERIOD = 0: update on every count-enable
    wr(6'd2, 16'd0);
    repeat (25) @(negedge clk);
    tick_gap("period0_gap", 1);
    // Prescaler
    wr(6'd0, 16'd0); wr(6'd1, 16'd3); wr(6'd2, 16'd9); wr(6'd0, 16'd1);
    tick_gap("presc_gap", 40);
`ifdef PWM_CENTER_ALIGN_EN
    wr(6'd0, 16'd0); wr(6'd1, 16'd0); wr(6'd2, 16'd4); wr(6'd3, 16'd2); wr(6'd0, 16'd3);
    tick_gap("center_gap", 8);
`endif
    // Randomized configurations with live shadow writes and stray addresses
    repeat (6) begin
      wr(6'd0, 16'd0);
      wr(6'd1, 16'($urandom_range(0, 2)));
      wr(6'd2, 16'($urandom_range(0, 12)));
      for (int i = 0; i < CH; i++) wr(6'(3 + i), 16'($urandom_range(0, 15)));
      wr(6'd0, 16'(1 | ($urandom_range(0, 1) << 1)));
      repeat ($urandom_range(60, 150)) begin
        if ($urandom_range(0, 7) == 0) wr(6'($urandom_range(2, 20)), 16'($urandom_range(0, 15)));
        else @(negedge clk);
      end
    end
    // Reset mid-period
    wr(6'd2, 16'd9);
    rd_rand = 1'b0;
    repeat (13) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_pwm", int'(pwm_out), 0);
    chk("midrst_tick", int'(update_tick), 0);
    chk("midrst_rd", int'(rd_data), 0);
    @(negedge clk);
    resetn = 1'b1;
    any = 0;
    repeat (20) begin
      @(negedge clk);
      any |= int'(pwm_out) | int'(update_tick);
    end
    chk("period_readback_after_rst", int'(rd_data), 0);
    chk("idle_after_rst_quiet", any, 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
